// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the 5-stage pipeline.
// Shadows the EX/MEM/WB register fields and drives the EX operand mux selects.
module fwd_hazard_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_dst,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        flush,
    input  logic        ext_stall,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        stall,
    output logic [15:0] stall_count
);

    logic        exValid_q, exValid_d;
    logic [4:0]  exRs_q, exRs_d;
    logic [4:0]  exRt_q, exRt_d;
    logic [4:0]  exDst_q, exDst_d;
    logic        exRegwrite_q, exRegwrite_d;
    logic        exMemread_q, exMemread_d;
    logic        memValid_q, memValid_d;
    logic [4:0]  memDst_q, memDst_d;
    logic        memRegwrite_q, memRegwrite_d;
    logic        wbValid_q, wbValid_d;
    logic [4:0]  wbDst_q, wbDst_d;
    logic        wbRegwrite_q, wbRegwrite_d;
    logic [15:0] stallCount_q, stallCount_d;

    logic memWritesA, memWritesB, wbWritesA, wbWritesB;
    logic exIsLoad;

    // r0 is excluded once, through the EX source check below.
    assign memWritesA = memValid_q && memRegwrite_q && (memDst_q == exRs_q);
    assign memWritesB = memValid_q && memRegwrite_q && (memDst_q == exRt_q);
    assign wbWritesA  = wbValid_q && wbRegwrite_q && (wbDst_q == exRs_q);
    assign wbWritesB  = wbValid_q && wbRegwrite_q && (wbDst_q == exRt_q);

    always_comb begin
        fwd_a = 2'd0;
        if (exValid_q && (exRs_q != 5'd0)) begin
            if (memWritesA)
                fwd_a = 2'd1;
            else if (wbWritesA)
                fwd_a = 2'd2;
        end
    end

    always_comb begin
        fwd_b = 2'd0;
        if (exValid_q && (exRt_q != 5'd0)) begin
            if (memWritesB)
                fwd_b = 2'd1;
            else if (wbWritesB)
                fwd_b = 2'd2;
        end
    end

    assign exIsLoad = exValid_q && exMemread_q && exRegwrite_q && (exDst_q != 5'd0);
    assign stall    = id_valid && !flush && exIsLoad &&
                      ((exDst_q == id_rs) || (exDst_q == id_rt));

    always_comb begin
        memValid_d    = exValid_q;
        memDst_d      = exDst_q;
        memRegwrite_d = exRegwrite_q;
        wbValid_d     = memValid_q;
        wbDst_d       = memDst_q;
        wbRegwrite_d  = memRegwrite_q;
        exValid_d     = 1'b0;
        exRs_d        = 5'd0;
        exRt_d        = 5'd0;
        exDst_d       = 5'd0;
        exRegwrite_d  = 1'b0;
        exMemread_d   = 1'b0;
        // A stalled or flushed ID instruction leaves a bubble behind in EX.
        if (id_valid && !flush && !stall) begin
            exValid_d    = 1'b1;
            exRs_d       = id_rs;
            exRt_d       = id_rt;
            exDst_d      = id_dst;
            exRegwrite_d = id_regwrite;
            exMemread_d  = id_memread;
        end
        stallCount_d = stallCount_q;
        if (stall && (stallCount_q != 16'hFFFF))
            stallCount_d = stallCount_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exValid_q     <= 1'b0;
            exRs_q        <= 5'd0;
            exRt_q        <= 5'd0;
            exDst_q       <= 5'd0;
            exRegwrite_q  <= 1'b0;
            exMemread_q   <= 1'b0;
            memValid_q    <= 1'b0;
            memDst_q      <= 5'd0;
            memRegwrite_q <= 1'b0;
            wbValid_q     <= 1'b0;
            wbDst_q       <= 5'd0;
            wbRegwrite_q  <= 1'b0;
            stallCount_q  <= 16'd0;
        end else if (!ext_stall) begin
            exValid_q     <= exValid_d;
            exRs_q        <= exRs_d;
            exRt_q        <= exRt_d;
            exDst_q       <= exDst_d;
            exRegwrite_q  <= exRegwrite_d;
            exMemread_q   <= exMemread_d;
            memValid_q    <= memValid_d;
            memDst_q      <= memDst_d;
            memRegwrite_q <= memRegwrite_d;
            wbValid_q     <= wbValid_d;
            wbDst_q       <= wbDst_d;
            wbRegwrite_q  <= wbRegwrite_d;
            stallCount_q  <= stallCount_d;
        end
    end

    assign stall_count = stallCount_q;

endmodule
